// File: rtl/tree_feature_loader.sv
// Assembles a beat-serial feature frame into a parallel vector for a tree classifier,
// waits for the classifier to settle, then holds the registered class result for a consumer.
module tree_feature_loader #(
    parameter int unsigned FEAT_W   = 51,
    parameter int unsigned BEAT_W   = 8,
    parameter int unsigned EVAL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic [FEAT_W-1:0] feat,
    input  logic              cls_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_class,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned NBEATS = (FEAT_W + BEAT_W - 1) / BEAT_W;
    localparam int unsigned BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(NBEATS - 1);
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(EVAL_LAT);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [BCNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [FEAT_W-1:0]   feat_nxt;
    logic [FEAT_W-1:0]   beat_merged;
    logic                m_class_nxt;
    logic                frame_err_nxt;
    logic [CNT_W-1:0]    frame_cnt_nxt;
    logic                accept;

    assign accept = s_valid && s_ready;

    // Current beat overlays its slice of feat; bits past FEAT_W have no home and are dropped.
    for (genvar g = 0; g < FEAT_W; g++) begin : g_map
        localparam int unsigned BK = g / BEAT_W;
        localparam int unsigned BJ = g % BEAT_W;
        assign beat_merged[g] = (beat_cnt == BCNT_W'(BK)) ? s_data[BJ] : feat[g];
    end

    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        wait_cnt_nxt  = wait_cnt;
        feat_nxt      = feat;
        m_class_nxt   = m_class;
        frame_err_nxt = 1'b0;
        frame_cnt_nxt = frame_cnt;

        unique case (state)
            COLLECT: begin
                if (accept) begin
                    if (beat_cnt == LAST_BEAT) begin
                        if (s_last) begin
                            feat_nxt     = beat_merged;
                            wait_cnt_nxt = WAIT_INIT;
                            state_nxt    = EVAL;
                        end else begin
                            frame_err_nxt = 1'b1;
                            feat_nxt      = '0;
                            beat_cnt_nxt  = '0;
                        end
                    end else if (s_last) begin
                        frame_err_nxt = 1'b1;
                        feat_nxt      = '0;
                        beat_cnt_nxt  = '0;
                    end else begin
                        feat_nxt     = beat_merged;
                        beat_cnt_nxt = beat_cnt + BCNT_W'(1);
                    end
                end
            end

            // feat is frozen here so the classifier sees a stable input while it settles.
            EVAL: begin
                if (wait_cnt <= WCNT_W'(1)) begin
                    m_class_nxt  = cls_in;
                    wait_cnt_nxt = '0;
                    state_nxt    = HOLD;
                end else begin
                    wait_cnt_nxt = wait_cnt - WCNT_W'(1);
                end
            end

            HOLD: begin
                if (m_ready) begin
                    frame_cnt_nxt = frame_cnt + CNT_W'(1);
                    feat_nxt      = '0;
                    beat_cnt_nxt  = '0;
                    state_nxt     = COLLECT;
                end
            end

            default: begin
                feat_nxt     = '0;
                beat_cnt_nxt = '0;
                wait_cnt_nxt = '0;
                state_nxt    = COLLECT;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            feat      <= '0;
            m_valid   <= 1'b0;
            m_class   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            s_ready   <= 1'b1;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            feat      <= feat_nxt;
            m_valid   <= (state_nxt == HOLD);
            m_class   <= m_class_nxt;
            frame_err <= frame_err_nxt;
            frame_cnt <= frame_cnt_nxt;
            s_ready   <= (state_nxt == COLLECT);
        end
    end

endmodule

// File: tb/tb_tree_feature_loader.sv
// Directed and randomized frames against a frame-level reference model of the feature loader.
module tb_tree_feature_loader;

    localparam int unsigned FEAT_W   = 51;
    localparam int unsigned BEAT_W   = 8;
    localparam int unsigned EVAL_LAT = 1;
    localparam int unsigned NBEATS   = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [BEAT_W-1:0] s_data;
    logic              s_last;
    logic [FEAT_W-1:0] feat;
    logic              cls_in;
    logic              m_valid;
    logic              m_ready;
    logic              m_class;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    logic [BEAT_W-1:0] beats [NBEATS];

    tree_feature_loader #(
        .FEAT_W  (FEAT_W),
        .BEAT_W  (BEAT_W),
        .EVAL_LAT(EVAL_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .feat     (feat),
        .cls_in   (cls_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_class  (m_class),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in decision tree: root splits on bit 0.
    function automatic logic tree_fn(input logic [FEAT_W-1:0] f);
        return f[0] ? f[50] : (f[17] ^ f[33]);
    endfunction

    assign cls_in = tree_fn(feat);

    // Frame as one little-endian word of beats, truncated to the feature width.
    function automatic logic [FEAT_W-1:0] frame_vec();
        logic [NBEATS*BEAT_W-1:0] wide;
        wide = '0;
        for (int k = NBEATS - 1; k >= 0; k--) wide = {wide[NBEATS*BEAT_W-BEAT_W-1:0], beats[k]};
        return FEAT_W'(wide);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic last, input bit gaps);
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_ready) check("beat_ready_timeout", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = BEAT_W'($urandom);
    endtask

    task automatic deliver(input int hold);
        int n;
        logic exp_class;
        exp_class = tree_fn(frame_vec());
        check("feat_eval", 64'(feat), 64'(frame_vec()));
        check("eval_no_valid", 64'(m_valid), 64'd0);
        check("eval_no_ready", 64'(s_ready), 64'd0);
        tick();
        check("result_latency", 64'(m_valid), 64'd1);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        if (!m_valid) check("result_timeout", 64'(m_valid), 64'd1);
        check("m_class", 64'(m_class), 64'(exp_class));
        m_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_valid", 64'(m_valid), 64'd1);
            check("bp_class", 64'(m_class), 64'(exp_class));
            check("bp_ready", 64'(s_ready), 64'd0);
            check("bp_cnt", 64'(frame_cnt), 64'(exp_cnt));
        end
        // A beat offered during the handover must not be taken.
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 65536;
        check("cnt_inc", 64'(frame_cnt), 64'(exp_cnt));
        check("post_valid", 64'(m_valid), 64'd0);
        check("post_ready", 64'(s_ready), 64'd1);
        check("post_feat", 64'(feat), 64'd0);
        tick();
        check("handover_no_accept", 64'(frame_err), 64'd0);
        check("cnt_once", 64'(frame_cnt), 64'(exp_cnt));
    endtask

    task automatic run_frame(input int hold, input bit gaps);
        for (int k = 0; k < NBEATS; k++) beats[k] = BEAT_W'($urandom);
        for (int k = 0; k < NBEATS; k++) send_beat(beats[k], (k == NBEATS - 1), gaps);
        deliver(hold);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_feat"}, 64'(feat), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_class"}, 64'(m_class), 64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        check("reset_release_ready", 64'(s_ready), 64'd1);
        tick();
        check("idle_ready", 64'(s_ready), 64'd1);

        // Nominal frame
        beats = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
        for (int k = 0; k < NBEATS; k++) send_beat(beats[k], (k == NBEATS - 1), 1'b0);
        check("nominal_feat", 64'(feat), 64'h0004_0000_0000_0001);
        check("nominal_cls", 64'(tree_fn(frame_vec())), 64'd1);
        deliver(0);
        check("nominal_cnt", 64'(frame_cnt), 64'd1);

        // Backpressure
        run_frame(20, 1'b0);

        // Early last on beat 3
        for (int k = 0; k < 3; k++) send_beat(BEAT_W'($urandom), 1'b0, 1'b0);
        send_beat(BEAT_W'($urandom), 1'b1, 1'b0);
        check("early_err", 64'(frame_err), 64'd1);
        check("early_feat", 64'(feat), 64'd0);
        check("early_ready", 64'(s_ready), 64'd1);
        tick();
        check("early_err_pulse", 64'(frame_err), 64'd0);
        run_frame(2, 1'b1);

        // Missing last on the final beat
        for (int k = 0; k < NBEATS; k++) send_beat(BEAT_W'($urandom), 1'b0, 1'b0);
        check("miss_err", 64'(frame_err), 64'd1);
        check("miss_feat", 64'(feat), 64'd0);
        check("miss_valid", 64'(m_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("miss_no_valid", 64'(m_valid), 64'd0);
            check("miss_err_pulse", 64'(frame_err), 64'd0);
        end
        run_frame(1, 1'b0);

        // Mid-frame reset after beat 4
        for (int k = 0; k < 5; k++) send_beat(BEAT_W'($urandom) | 8'h01, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        check("midrst_ready", 64'(s_ready), 64'd1);
        rst = 1'b0;
        exp_cnt = 0;
        run_frame(0, 1'b0);
        check("midrst_cnt", 64'(frame_cnt), 64'd1);

        // Randomized frames
        for (int f = 0; f < 15; f++) run_frame(int'($urandom_range(0, 5)), 1'b1);

        // Counter wrap: stand in for 65535 prior deliveries
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        exp_cnt = 65535;
        tick();
        check("preset_cnt", 64'(frame_cnt), 64'hFFFF);
        run_frame(0, 1'b0);
        check("wrap_cnt", 64'(frame_cnt), 64'h0000);
        run_frame(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
